// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: memory access sizes and the LSU sequencer states.
package riscv_pkg;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } lsu_state_t;

endpackage

// File: rtl/load_align.sv
// Load data aligner: selects the addressed byte/half from a bus word and extends it.
module load_align
   import riscv_pkg::*;
(
   input  logic [31:0] bus_rdata_i,
   input  logic [1:0]  offset_i,
   input  logic [1:0]  size_i,
   input  logic        sign_i,
   output logic [31:0] result_o
);

   logic [31:0] shifted;

   // Shift the addressed lane down to bit 0, then sign/zero extend by size.
   always_comb begin
      shifted = bus_rdata_i >> {offset_i, 3'b000};
      case (size_i)
         MEM_BYTE: result_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
         MEM_HALF: result_o = {{16{sign_i & shifted[15]}}, shifted[15:0]};
         default:  result_o = bus_rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_controller.sv
// Multi-cycle load/store sequencer between the core datapath and a req/gnt memory bus.
module lsu_controller
   import riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_size,
   input  logic        mem_sign,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        misaligned,
   output logic        fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata,
   input  logic        bus_err
);

   localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

   lsu_state_t  state_q, state_d;
   logic        we_q, sign_q;
   logic [1:0]  off_q, size_q;
   logic [31:0] bus_addr_q, bus_wdata_q;
   logic [3:0]  bus_be_q;
   logic [31:0] rdata_q, rdata_d;
   logic        rdata_valid_q, rdata_valid_d;
   logic        fault_q, fault_d;
   logic [31:0] cnt_q, cnt_d;

   logic        access, is_misal, start, timeout_hit;
   logic [3:0]  be_calc;
   logic [31:0] wdata_rep, ld_res;

   assign access      = mem_read | mem_write;
   // Size 2'b11 behaves as a word, so any size with bit 1 set needs word alignment.
   assign is_misal    = ((mem_size == MEM_HALF) & addr[0]) | (mem_size[1] & (addr[1:0] != 2'b00));
   assign start       = (state_q == IDLE) & access & ~is_misal;
   assign timeout_hit = TO_EN & (cnt_q == TO_LAST);

   assign stall       = ~rst & (start | (state_q == REQ) | (state_q == WAIT));
   assign misaligned  = ~rst & (state_q == IDLE) & access & is_misal;
   assign bus_req     = (state_q == REQ);
   assign bus_we      = we_q;
   assign bus_addr    = bus_addr_q;
   assign bus_be      = bus_be_q;
   assign bus_wdata   = bus_wdata_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;
   assign fault       = fault_q;

   load_align u_align (
      .bus_rdata_i (bus_rdata),
      .offset_i    (off_q),
      .size_i      (size_q),
      .sign_i      (sign_q),
      .result_o    (ld_res)
   );

   // Byte enables and lane-replicated store data for the access being launched.
   always_comb begin
      case (mem_size)
         MEM_BYTE: begin
            be_calc   = 4'b0001 << addr[1:0];
            wdata_rep = {4{wdata[7:0]}};
         end
         MEM_HALF: begin
            be_calc   = 4'b0011 << {addr[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
         end
         default: begin
            be_calc   = 4'b1111;
            wdata_rep = wdata;
         end
      endcase
   end

   // Next state, timeout counter and completion pulses; a bus response in the
   // final timeout cycle still wins, since the transfer did complete.
   always_comb begin
      state_d       = state_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      fault_d       = 1'b0;
      cnt_d         = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = REQ;
               cnt_d   = '0;
            end
         end
         REQ: begin
            cnt_d = cnt_q + 32'd1;
            if (bus_gnt) begin
               if (we_q) begin
                  state_d = DONE;
                  fault_d = bus_err;
               end else begin
                  state_d = WAIT;
               end
            end else if (timeout_hit) begin
               state_d = DONE;
               fault_d = 1'b1;
               if (!we_q) begin
                  rdata_d       = '0;
                  rdata_valid_d = 1'b1;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 32'd1;
            if (bus_rvalid) begin
               state_d       = DONE;
               rdata_valid_d = 1'b1;
               fault_d       = bus_err;
               rdata_d       = bus_err ? '0 : ld_res;
            end else if (timeout_hit) begin
               state_d       = DONE;
               rdata_valid_d = 1'b1;
               fault_d       = 1'b1;
               rdata_d       = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counter and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         fault_q       <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         fault_q       <= fault_d;
         cnt_q         <= cnt_d;
      end
   end

   // Capture the access on launch; bus fields then stay stable until the next launch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q        <= 1'b0;
         sign_q      <= 1'b0;
         off_q       <= '0;
         size_q      <= '0;
         bus_addr_q  <= '0;
         bus_be_q    <= '0;
         bus_wdata_q <= '0;
      end else if (start) begin
         we_q        <= ~mem_read;
         sign_q      <= mem_sign;
         off_q       <= addr[1:0];
         size_q      <= mem_size;
         bus_addr_q  <= {addr[31:2], 2'b00};
         bus_be_q    <= be_calc;
         bus_wdata_q <= wdata_rep;
      end
   end

endmodule

// File: tb/tb_lsu_controller.sv
// Directed plus randomized bench for lsu_controller against an arithmetic access model.
module tb_lsu_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write, mem_sign;
   logic [1:0]  mem_size;
   logic [31:0] addr, wdata;
   logic        bus_gnt, bus_rvalid, bus_err;
   logic [31:0] bus_rdata;
   logic        stall, rdata_valid, misaligned, fault, bus_req, bus_we;
   logic [31:0] rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_be;

   // second instance with a short timeout; shares data inputs, own handshakes
   logic        t_read, t_write, t_gnt, t_rvalid;
   logic        t_stall, t_rdata_valid, t_misaligned, t_fault, t_bus_req, t_bus_we;
   logic [31:0] t_rdata, t_bus_addr, t_bus_wdata;
   logic [3:0]  t_bus_be;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] model_rdata = 32'h0;

   always #5 clk = ~clk;

   lsu_controller u_dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_size(mem_size), .mem_sign(mem_sign), .addr(addr), .wdata(wdata),
      .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .misaligned(misaligned),
      .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   lsu_controller #(.TIMEOUT_CYCLES(4)) u_dut_to (
      .clk(clk), .rst(rst), .mem_read(t_read), .mem_write(t_write),
      .mem_size(mem_size), .mem_sign(mem_sign), .addr(addr), .wdata(wdata),
      .stall(t_stall), .rdata(t_rdata), .rdata_valid(t_rdata_valid), .misaligned(t_misaligned),
      .fault(t_fault), .bus_req(t_bus_req), .bus_we(t_bus_we), .bus_addr(t_bus_addr),
      .bus_be(t_bus_be), .bus_wdata(t_bus_wdata), .bus_gnt(t_gnt), .bus_rvalid(t_rvalid),
      .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected load result from plain arithmetic on the bus word.
   function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input bit sg);
      logic [31:0] v;
      v = w >> (8 * int'(off));
      if (sz == 2'd0) begin
         v = v % 32'd256;
         if (sg && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = v % 32'd65536;
         if (sg && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] off);
      if (sz == 2'd0) return 4'(32'd1 << off);
      if (sz == 2'd1) return 4'(32'd3 << off);
      return 4'hF;
   endfunction

   function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] wd);
      if (sz == 2'd0) return (wd % 32'd256) * 32'h0101_0101;
      if (sz == 2'd1) return (wd % 32'd65536) * 32'h0001_0001;
      return wd;
   endfunction

   // One complete aligned access on the main instance with given gnt/rvalid delays.
   task automatic do_access(input bit ld, input logic [1:0] sz, input bit sg,
                            input logic [31:0] a, input logic [31:0] wd, input int gd,
                            input int rd, input logic [31:0] rw, input bit er);
      int stalls = 0;
      int exp_stalls;
      @(posedge clk); #1;
      mem_read  = ld;
      mem_write = ld ? 1'($urandom % 2) : 1'b1;
      mem_size  = sz; mem_sign = sg; addr = a; wdata = wd;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
      @(negedge clk);
      chk("idle_misal", misaligned, 0);
      chk("idle_req", bus_req, 0);
      stalls += int'(stall);
      for (int k = 0; k <= gd; k++) begin
         @(posedge clk); #1;
         bus_gnt    = (k == gd);
         bus_err    = (k == gd) && !ld && er;
         bus_rvalid = 1'($urandom % 2);
         bus_rdata  = $urandom;
         @(negedge clk);
         chk("req_req", bus_req, 1);
         chk("req_addr", bus_addr, a - (a % 32'd4));
         chk("req_be", bus_be, exp_be(sz, a[1:0]));
         chk("req_we", bus_we, !ld);
         if (!ld) chk("req_wdata", bus_wdata, exp_wd(sz, wd));
         stalls += int'(stall);
      end
      if (ld) begin
         for (int k = 0; k <= rd; k++) begin
            @(posedge clk); #1;
            bus_gnt    = 1'b0;
            bus_err    = (k == rd) && er;
            bus_rvalid = (k == rd);
            bus_rdata  = (k == rd) ? rw : $urandom;
            @(negedge clk);
            chk("wait_req", bus_req, 0);
            stalls += int'(stall);
         end
      end
      @(posedge clk); #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
      @(negedge clk);
      exp_stalls = 2 + gd + (ld ? rd + 1 : 0);
      chk("stall_cycles", stalls, exp_stalls);
      chk("done_stall", stall, 0);
      chk("done_valid", rdata_valid, ld);
      chk("done_fault", fault, er);
      chk("done_req", bus_req, 0);
      if (ld) model_rdata = er ? 32'h0 : exp_load(rw, a[1:0], sz, sg);
      chk("done_rdata", rdata, model_rdata);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      chk("after_flags", {28'h0, stall, rdata_valid, fault, bus_req}, 0);
      chk("rdata_hold", rdata, model_rdata);
   endtask

   task automatic do_misal(input logic [1:0] sz, input logic [31:0] a);
      @(posedge clk); #1;
      mem_read = 1'b1; mem_write = 1'($urandom % 2); mem_size = sz; addr = a;
      @(negedge clk);
      chk("mis_flag", misaligned, 1);
      chk("mis_stall", stall, 0);
      chk("mis_req", bus_req, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mis_flag_hold", misaligned, 1);
      chk("mis_req_hold", bus_req, 0);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      chk("mis_clear", misaligned, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  sz;
      logic [31:0] a;
      rst = 1'b1;
      mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b10; mem_sign = 1'b0;
      addr = 32'h0000_0002; wdata = 32'h0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;
      t_read = 1'b0; t_write = 1'b0; t_gnt = 1'b0; t_rvalid = 1'b0;

      // reset: outputs zero, combinational flags masked even with an access presented
      #2;
      chk("rst_stall", stall, 0);
      chk("rst_misal", misaligned, 0);
      chk("rst_req", bus_req, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_pulses", {30'h0, rdata_valid, fault}, 0);
      chk("rst_bus", {bus_addr[27:0], bus_be}, 0);
      @(posedge clk); #1;
      mem_read = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: LBU at byte 3
      do_access(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234, 1'b0);
      // 2: LH at offset 2 with a 3-cycle grant delay
      do_access(1'b1, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 3, 0, 32'h8001_0000, 1'b0);
      // 3: SB at byte 1
      do_access(1'b0, 2'b00, 1'b0, 32'h0000_3001, 32'h0000_00AB, 0, 0, 32'h0, 1'b0);
      // 4: misaligned LW and LH
      do_misal(2'b10, 32'h0000_4002);
      do_misal(2'b01, 32'h0000_4001);

      // 6: reset while waiting for read data, then a late rvalid
      @(posedge clk); #1;
      mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b10; addr = 32'h0000_5000;
      @(posedge clk); #1;
      bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("rstw_req", bus_req, 0);
      chk("rstw_stall", stall, 0);
      chk("rstw_rdata", rdata, 0);
      chk("rstw_bus", {bus_addr[27:0], bus_be}, 0);
      model_rdata = 32'h0;
      @(posedge clk); #1;
      rst = 1'b0; mem_read = 1'b0;
      bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("late_valid", rdata_valid, 0);
      chk("late_stall", stall, 0);
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
      @(negedge clk);
      chk("late_valid2", rdata_valid, 0);
      chk("late_rdata", rdata, 0);
      do_access(1'b1, 2'b10, 1'b0, 32'h0000_5004, 32'h0, 1, 1, 32'hCAFE_F00D, 1'b0);

      // 5: timeout instance; preload a result so the forced zero is visible
      @(posedge clk); #1;
      t_read = 1'b1; mem_size = 2'b10; addr = 32'h0000_6000;
      @(posedge clk); #1;
      t_gnt = 1'b1;
      @(posedge clk); #1;
      t_gnt = 1'b0; t_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      t_rvalid = 1'b0;
      @(negedge clk);
      chk("to_pre_rdata", t_rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      t_read = 1'b0;
      @(posedge clk); #1;
      t_read = 1'b1; addr = 32'h0000_6004;
      @(negedge clk);
      chk("to_idle_stall", t_stall, 1);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("to_req", t_bus_req, 1);
         chk("to_nofault", t_fault, 0);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_fault", t_fault, 1);
      chk("to_rdata", t_rdata, 0);
      chk("to_valid", t_rdata_valid, 1);
      chk("to_req_off", t_bus_req, 0);
      chk("to_stall", t_stall, 0);
      @(posedge clk); #1;
      t_read = 1'b0;
      @(negedge clk);
      chk("to_fault_end", t_fault, 0);
      // SW with bus_err at grant on the same instance
      @(posedge clk); #1;
      t_write = 1'b1; addr = 32'h0000_6008; wdata = 32'h1111_2222;
      @(posedge clk); #1;
      t_gnt = 1'b1; bus_err = 1'b1;
      @(posedge clk); #1;
      t_gnt = 1'b0; bus_err = 1'b0;
      @(negedge clk);
      chk("sw_err_fault", t_fault, 1);
      chk("sw_err_valid", t_rdata_valid, 0);
      @(posedge clk); #1;
      t_write = 1'b0;

      // SW with bus_err on the main instance
      do_access(1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'h5A5A_A5A5, 1, 0, 32'h0, 1'b1);

      // randomized aligned accesses
      for (int i = 0; i < 40; i++) begin
         sz = 2'($urandom % 4);
         a  = $urandom;
         if (sz == 2'b01) a[0] = 1'b0;
         if (sz[1]) a[1:0] = 2'b00;
         do_access(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom,
                   int'($urandom % 4), int'($urandom % 4), $urandom, ($urandom % 8) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lsu_controller.md
Name: lsu_controller

Overview:
Multi-cycle load/store sequencer between the RV32I core datapath and a request/grant data-memory bus. Consumes MemRead, MemWrite, MemSize and MemSign from the main decoder plus the ALU-computed address. Generates word-aligned bus transactions with byte enables and aligns and extends load data. Stalls the core until each access completes, and flags misaligned, bus-error and timeout faults.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before forced completion with fault; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
mem_read  in  1  load request from decoder
mem_write  in  1  store request from decoder
mem_size  in  2  00=byte, 01=half, 10=word; 11 treated as word
mem_sign  in  1  1=sign-extend load, 0=zero-extend
addr  in  32  byte address from ALU
wdata  in  32  store data (rs2)
stall  out  1  freeze PC/pipeline while high
rdata  out  32  aligned/extended load result, valid with rdata_valid
rdata_valid  out  1  one-cycle pulse, load complete
misaligned  out  1  combinational, access rejected for alignment
fault  out  1  one-cycle pulse, bus error or timeout
bus_req  out  1  transaction request
bus_we  out  1  1=write
bus_addr  out  32  word address, {addr[31:2],2'b00}
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_gnt  in  1  request accepted
bus_rvalid  in  1  read data valid
bus_rdata  in  32  read data word
bus_err  in  1  error, sampled with bus_gnt (write) or bus_rvalid (read)

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Clock is clk only; rst is asynchronous and active-high.
- Reset (asynchronous, any state): state=IDLE. All registered outputs are 0. stall and misaligned are forced 0 while rst is high. Any in-flight transaction is abandoned and bus_req drops immediately.
- Access priority: mem_read over mem_write if both are high.
- Alignment:
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - In IDLE a misaligned access sets misaligned=1 combinationally, with no stall and no bus activity. The state stays IDLE.
- IDLE -> REQ on an aligned access:
  - stall=1 combinationally in the same cycle.
  - addr[1:0], size, sign and we are latched.
  - bus_addr, bus_be and bus_wdata are registered.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- Store data replication: byte is {4{wdata[7:0]}}, half is {2{wdata[15:0]}}, word is wdata.
- REQ:
  - bus_req=1, with bus_addr/bus_be/bus_we/bus_wdata held stable until bus_gnt.
  - On bus_gnt, a read goes to WAIT. A write goes to DONE, with fault set if bus_err.
  - bus_req deasserts in the cycle after gnt.
- WAIT:
  - bus_req=0. On bus_rvalid go to DONE.
  - Extraction: shift bus_rdata right by 8*addr_q[1:0], then sign- or zero-extend from bit 7 (byte) or bit 15 (half). Register the result into rdata.
  - If bus_err: rdata=0 and fault=1.
- Timeout: the counter clears on IDLE->REQ and increments in REQ/WAIT. Reaching TIMEOUT_CYCLES forces DONE with fault=1, rdata=0 and bus_req=0.
- DONE:
  - stall=0. rdata_valid=1 for loads; fault pulses here when applicable.
  - mem_read/mem_write are ignored, because the same instruction is still presented during this cycle.
  - Unconditional DONE->IDLE. rdata holds its value until the next load completes.
- stall = (IDLE & aligned access) | REQ | WAIT.
- Minimum latency:
  - Load: 4 cycles (IDLE, REQ with gnt, WAIT with rvalid, DONE), with stall high for 3 cycles.
  - Store: 3 cycles, with stall high for 2 cycles.
- bus_rvalid seen while in REQ is ignored.

Decomposition:
- Shared package riscv_pkg:
  - mem_size constants MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10.
  - lsu_state_t enum {IDLE,REQ,WAIT,DONE}.
- One sub-module, load_align (combinational): inputs bus_rdata, offset[1:0], size, sign; output the 32-bit extended result. It is reused by the later pipelined core.

Test Plan:
1. LBU, addr=0x1003, bus_rdata=0x80FF_1234, gnt in REQ cycle 1, rvalid next cycle: bus_addr=0x1000, bus_be=4'b1000, rdata=0x0000_0080, rdata_valid in cycle 4, stall high for exactly 3 cycles.
2. LH, addr=0x2002, bus_rdata=0x8001_0000, gnt delayed 3 cycles: bus_req held 4 cycles with stable bus_addr=0x2000 and bus_be=4'b1100, rdata=0xFFFF_8001.
3. SB, addr=0x3001, wdata=0x0000_00AB: bus_we=1, bus_be=4'b0010, bus_wdata=0xABAB_ABAB, completes 1 cycle after gnt, no rdata_valid.
4. LW, addr=0x4002: misaligned=1 in the same cycle, stall=0, bus_req never asserted, state stays IDLE.
5. LW with TIMEOUT_CYCLES=4 and bus_gnt never asserted: fault pulses in DONE after 4 REQ cycles, rdata=0, bus_req=0. Then SW with bus_err=1 at gnt: fault pulses.
6. rst asserted in WAIT, then a late rvalid arrives: outputs are 0 immediately, no rdata_valid, and the next LW completes normally.
